// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, fixed AXI
// field values, lane strobes and the strobe-to-word-count helper.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ISSUE,
    ST_RESP,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [7:0] LANE0_STRB = 8'h0F;
  localparam logic [7:0] LANE1_STRB = 8'hF0;

  // Number of 32-bit words carried by a beat, i.e. popcount(strb)/4.
  function automatic int unsigned strb_words(input logic [7:0] strb);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (strb[i]) n++;
    end
    return n / 4;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Instruction stream plus AXI write channels between the loader and memory.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);
  logic              s_valid_i;
  logic              s_ready_o;
  logic [31:0]       s_data_i;
  logic              s_last_i;

  logic              aw_valid_o;
  logic              aw_ready_i;
  logic [ADDR_W-1:0] aw_addr_o;
  logic [7:0]        aw_len_o;
  logic [2:0]        aw_size_o;
  logic [1:0]        aw_burst_o;
  logic [3:0]        aw_id_o;

  logic              w_valid_o;
  logic              w_ready_i;
  logic [DATA_W-1:0] w_data_o;
  logic [DATA_W/8-1:0] w_strb_o;
  logic              w_last_o;

  logic              b_valid_i;
  logic              b_ready_o;
  logic [1:0]        b_resp_i;

  modport master (
    input  s_valid_i, s_data_i, s_last_i,
    output s_ready_o,
    output aw_valid_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, aw_id_o,
    input  aw_ready_i,
    output w_valid_o, w_data_o, w_strb_o, w_last_o,
    input  w_ready_i,
    input  b_valid_i, b_resp_i,
    output b_ready_o
  );

  modport slave (
    output s_valid_i, s_data_i, s_last_i,
    input  s_ready_o,
    input  aw_valid_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, aw_id_o,
    output aw_ready_i,
    input  w_valid_o, w_data_o, w_strb_o, w_last_o,
    output w_ready_i,
    output b_valid_i, b_resp_i,
    input  b_ready_o
  );
endinterface

// File: rtl/prog_loader_packer.sv
// Packs 32-bit instruction words into 64-bit beats: lane pointer, beat
// buffer and accumulated byte strobes.
module prog_loader_packer
  import prog_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        lane_init_i,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [31:0] word_i,
  output logic        lane_o,
  output logic [63:0] data_o,
  output logic [7:0]  strb_o
);

  logic        lane_q, lane_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  strb_q, strb_d;

  always_comb begin
    lane_d = lane_q;
    data_d = data_q;
    strb_d = strb_q;
    if (start_i) begin
      lane_d = lane_init_i;
      data_d = '0;
      strb_d = '0;
    end else begin
      if (clear_i) begin
        data_d = '0;
        strb_d = '0;
      end
      if (push_i) begin
        if (lane_q) begin
          data_d[63:32] = word_i;
          strb_d        = strb_d | LANE1_STRB;
        end else begin
          data_d[31:0]  = word_i;
          strb_d        = strb_d | LANE0_STRB;
        end
        lane_d = ~lane_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q <= 1'b0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      lane_q <= lane_d;
      data_q <= data_d;
      strb_q <= strb_d;
    end
  end

  assign lane_o = lane_q;
  assign data_o = data_q;
  assign strb_o = strb_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: collects an instruction stream into 64-bit beats and writes
// each beat to memory as a single-beat AXI write, one outstanding at a time.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  prog_loader_if.master     bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  words_o
);

  localparam int unsigned BEAT_BYTES = DATA_W / 8;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              last_q, last_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic              s_ready, aw_valid, w_valid, b_ready;
  logic              aw_hs, w_hs;
  logic              pk_start, pk_clear, pk_push, pk_lane;
  logic [63:0]       pk_data;
  logic [7:0]        pk_strb;

  prog_loader_packer u_packer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (pk_start),
    .lane_init_i(base_addr_i[2]),
    .clear_i    (pk_clear),
    .push_i     (pk_push),
    .word_i     (bus.s_data_i),
    .lane_o     (pk_lane),
    .data_o     (pk_data),
    .strb_o     (pk_strb)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    words_d   = words_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    pk_start  = 1'b0;
    pk_clear  = 1'b0;
    pk_push   = 1'b0;

    s_ready  = (state_q == ST_COLLECT);
    aw_valid = (state_q == ST_ISSUE) && !aw_done_q;
    w_valid  = (state_q == ST_ISSUE) && !w_done_q;
    b_ready  = (state_q == ST_RESP);
    aw_hs    = aw_valid && bus.aw_ready_i;
    w_hs     = w_valid && bus.w_ready_i;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          pk_start = 1'b1;
          words_d  = '0;
          last_d   = 1'b0;
          addr_d   = {base_addr_i[ADDR_W-1:3], 3'b000};
          state_d  = (base_addr_i[1:0] != 2'b00) ? ST_ERR : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (bus.s_valid_i) begin
          pk_push = 1'b1;
          // Filling lane 1 and the last word close the beat; both together
          // still yield a single beat.
          if (pk_lane || bus.s_last_i) begin
            last_d    = bus.s_last_i;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.b_valid_i) begin
          if (bus.b_resp_i == AXI_RESP_OKAY) begin
            words_d = words_q + CNT_W'(strb_words(pk_strb));
            if (last_q) begin
              state_d = ST_DONE;
            end else begin
              pk_clear = 1'b1;
              addr_d   = addr_q + ADDR_W'(BEAT_BYTES);
              state_d  = ST_COLLECT;
            end
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      words_q   <= '0;
      last_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      words_q   <= words_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign bus.s_ready_o  = s_ready;
  assign bus.aw_valid_o = aw_valid;
  assign bus.aw_addr_o  = addr_q;
  assign bus.aw_len_o   = AXI_LEN_SINGLE;
  assign bus.aw_size_o  = AXI_SIZE_8B;
  assign bus.aw_burst_o = AXI_BURST_INCR;
  assign bus.aw_id_o    = '0;
  assign bus.w_valid_o  = w_valid;
  assign bus.w_data_o   = pk_data;
  assign bus.w_strb_o   = pk_strb;
  assign bus.w_last_o   = 1'b1;
  assign bus.b_ready_o  = b_ready;

  assign busy_o  = (state_q == ST_COLLECT) || (state_q == ST_ISSUE) || (state_q == ST_RESP);
  assign done_o  = (state_q == ST_DONE);
  assign err_o   = (state_q == ST_ERR);
  assign words_o = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of load scenarios run against a
// simple AXI slave model, plus hand sequences for misalignment and reset.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic        busy, done, err;
  logic [15:0] words;

  prog_loader_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  prog_loader #(.ADDR_W(32), .DATA_W(64), .CNT_W(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .base_addr_i(base),
    .bus        (bus),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .words_o    (words)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] WA = 32'hA0A0_0001;
  localparam logic [31:0] WB = 32'hB0B0_0002;
  localparam logic [31:0] WC = 32'hC0C0_0003;
  localparam logic [31:0] WD = 32'hD0D0_0004;
  localparam logic [31:0] WE = 32'hE0E0_0005;

  typedef struct {
    logic [31:0]       base;
    int unsigned       n;
    logic [4:0][31:0]  wd;
    logic [3:0][1:0]   resp;
    int unsigned       aw_dly;
    int unsigned       w_dly;
    int unsigned       exp_beats;
    logic [1:0][31:0]  ea;
    logic [1:0][63:0]  ed;
    logic [1:0][7:0]   es;
    logic [15:0]       exp_words;
    logic              exp_done;
    logic              exp_err;
  } scn_t;

  scn_t tbl[8];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.s_valid_i  = 1'b0;
    bus.s_data_i   = '0;
    bus.s_last_i   = 1'b0;
    bus.aw_ready_i = 1'b0;
    bus.w_ready_i  = 1'b0;
    bus.b_valid_i  = 1'b0;
    bus.b_resp_i   = 2'b00;
  endtask

  task automatic run_scn(input int k, input scn_t s);
    int unsigned idx, beat, nb, aw_cnt, w_cnt, viol, post_viol;
    logic aw_seen, w_seen, bv, timed_out;
    logic [31:0] ga[4];
    logic [63:0] gd[4];
    logic [7:0]  gs[4];
    idx = 0; beat = 0; nb = 0; aw_cnt = 0; w_cnt = 0; viol = 0; post_viol = 0;
    aw_seen = 1'b0; w_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin ga[i] = '0; gd[i] = '0; gs[i] = '0; end

    base = s.base; start = 1'b1;
    step;
    start = 1'b0;
    chk($sformatf("s%0d_start_status", k), {busy, done, err}, 3'b100);
    chk($sformatf("s%0d_start_words", k), words, 0);

    for (int cyc = 0; cyc < 300 && !(done || err); cyc++) begin
      bv = aw_seen && w_seen;
      bus.s_valid_i = (idx < s.n);
      bus.s_data_i  = (idx < s.n) ? s.wd[idx] : '0;
      bus.s_last_i  = (idx + 1 == s.n);
      if (bus.s_ready_o && (aw_seen || w_seen)) viol++;
      if (bus.s_valid_i && bus.s_ready_o) idx++;

      if (bus.aw_valid_o && !aw_seen) begin
        bus.aw_ready_i = (aw_cnt >= s.aw_dly);
        aw_cnt++;
        if (bus.aw_ready_i) begin
          if (beat < 4) ga[beat] = bus.aw_addr_o;
          aw_seen = 1'b1;
        end
      end else begin
        if (bus.aw_valid_o) viol++;
        bus.aw_ready_i = 1'b0;
      end

      if (bus.w_valid_o && !w_seen) begin
        bus.w_ready_i = (w_cnt >= s.w_dly);
        w_cnt++;
        if (bus.w_ready_i) begin
          if (beat < 4) begin gd[beat] = bus.w_data_o; gs[beat] = bus.w_strb_o; end
          w_seen = 1'b1;
        end
      end else begin
        if (bus.w_valid_o) viol++;
        bus.w_ready_i = 1'b0;
      end

      bus.b_valid_i = bv;
      bus.b_resp_i  = (beat < 4) ? s.resp[beat] : 2'b00;
      if (bv && bus.b_ready_o) begin
        nb++; beat++;
        aw_seen = 1'b0; w_seen = 1'b0; aw_cnt = 0; w_cnt = 0;
      end
      step;
    end
    timed_out = !(done || err);
    idle_inputs();

    chk($sformatf("s%0d_timeout", k), timed_out, 0);
    chk($sformatf("s%0d_beats", k), nb, s.exp_beats);
    for (int i = 0; i < 2; i++) begin
      if (i < int'(s.exp_beats)) begin
        chk($sformatf("s%0d_addr%0d", k, i), ga[i], s.ea[i]);
        chk($sformatf("s%0d_data%0d", k, i), gd[i], s.ed[i]);
        chk($sformatf("s%0d_strb%0d", k, i), gs[i], s.es[i]);
      end
    end
    chk($sformatf("s%0d_words", k), words, s.exp_words);
    chk($sformatf("s%0d_done_err", k), {done, err}, {s.exp_done, s.exp_err});
    chk($sformatf("s%0d_protocol", k), viol, 0);

    // Keep offering remaining words: nothing may be accepted or issued.
    for (int c = 0; c < 3; c++) begin
      bus.s_valid_i = (idx < s.n);
      bus.s_data_i  = (idx < s.n) ? s.wd[idx] : '0;
      if (bus.s_ready_o || bus.aw_valid_o || bus.w_valid_o || busy) post_viol++;
      step;
    end
    idle_inputs();
    chk($sformatf("s%0d_quiet_after", k), post_viol, 0);
    chk($sformatf("s%0d_hold", k), {done, err, words}, {s.exp_done, s.exp_err, s.exp_words});
  endtask

  initial begin
    int unsigned q;
    idle_inputs();

    tbl[0] = '{base: 32'h8000_0000, n: 3, wd: {32'h0, 32'h0, WC, WB, WA}, resp: '0,
               aw_dly: 0, w_dly: 0, exp_beats: 2,
               ea: {32'h8000_0008, 32'h8000_0000},
               ed: {64'h0000_0000_C0C0_0003, 64'hB0B0_0002_A0A0_0001},
               es: {8'h0F, 8'hFF}, exp_words: 16'd3, exp_done: 1'b1, exp_err: 1'b0};
    tbl[1] = '{base: 32'h8000_0004, n: 2, wd: {32'h0, 32'h0, 32'h0, WB, WA}, resp: '0,
               aw_dly: 0, w_dly: 0, exp_beats: 2,
               ea: {32'h8000_0008, 32'h8000_0000},
               ed: {64'h0000_0000_B0B0_0002, 64'hA0A0_0001_0000_0000},
               es: {8'h0F, 8'hF0}, exp_words: 16'd2, exp_done: 1'b1, exp_err: 1'b0};
    tbl[2] = '{base: 32'h8000_0000, n: 4, wd: {32'h0, WD, WC, WB, WA}, resp: '0,
               aw_dly: 3, w_dly: 0, exp_beats: 2,
               ea: {32'h8000_0008, 32'h8000_0000},
               ed: {64'hD0D0_0004_C0C0_0003, 64'hB0B0_0002_A0A0_0001},
               es: {8'hFF, 8'hFF}, exp_words: 16'd4, exp_done: 1'b1, exp_err: 1'b0};
    tbl[3] = '{base: 32'h0000_1000, n: 3, wd: {32'h0, 32'h0, WC, WB, WA}, resp: '0,
               aw_dly: 0, w_dly: 3, exp_beats: 2,
               ea: {32'h0000_1008, 32'h0000_1000},
               ed: {64'h0000_0000_C0C0_0003, 64'hB0B0_0002_A0A0_0001},
               es: {8'h0F, 8'hFF}, exp_words: 16'd3, exp_done: 1'b1, exp_err: 1'b0};
    tbl[4] = '{base: 32'h8000_0000, n: 5, wd: {WE, WD, WC, WB, WA},
               resp: {2'b00, 2'b00, 2'b10, 2'b00},
               aw_dly: 0, w_dly: 0, exp_beats: 2,
               ea: {32'h8000_0008, 32'h8000_0000},
               ed: {64'hD0D0_0004_C0C0_0003, 64'hB0B0_0002_A0A0_0001},
               es: {8'hFF, 8'hFF}, exp_words: 16'd2, exp_done: 1'b0, exp_err: 1'b1};
    tbl[5] = '{base: 32'hFFFF_FFF8, n: 3, wd: {32'h0, 32'h0, WC, WB, WA}, resp: '0,
               aw_dly: 1, w_dly: 1, exp_beats: 2,
               ea: {32'h0000_0000, 32'hFFFF_FFF8},
               ed: {64'h0000_0000_C0C0_0003, 64'hB0B0_0002_A0A0_0001},
               es: {8'h0F, 8'hFF}, exp_words: 16'd3, exp_done: 1'b1, exp_err: 1'b0};
    tbl[6] = '{base: 32'h0000_0104, n: 1, wd: {32'h0, 32'h0, 32'h0, 32'h0, WA}, resp: '0,
               aw_dly: 0, w_dly: 0, exp_beats: 1,
               ea: {32'h0, 32'h0000_0100},
               ed: {64'h0, 64'hA0A0_0001_0000_0000},
               es: {8'h00, 8'hF0}, exp_words: 16'd1, exp_done: 1'b1, exp_err: 1'b0};
    tbl[7] = '{base: 32'h0000_2000, n: 2, wd: {32'h0, 32'h0, 32'h0, WB, WA},
               resp: {2'b00, 2'b00, 2'b00, 2'b10},
               aw_dly: 0, w_dly: 0, exp_beats: 1,
               ea: {32'h0, 32'h0000_2000},
               ed: {64'h0, 64'hB0B0_0002_A0A0_0001},
               es: {8'h00, 8'hFF}, exp_words: 16'd0, exp_done: 1'b0, exp_err: 1'b1};

    // Reset state and fixed AXI fields.
    repeat (3) step;
    chk("rst_status", {busy, done, err, words}, 19'd0);
    chk("rst_handshakes", {bus.s_ready_o, bus.aw_valid_o, bus.w_valid_o, bus.b_ready_o}, 4'd0);
    chk("rst_addr", bus.aw_addr_o, 0);
    chk("rst_wdata", bus.w_data_o, 0);
    chk("rst_wstrb", bus.w_strb_o, 0);
    chk("axi_fixed", {bus.aw_len_o, bus.aw_size_o, bus.aw_burst_o, bus.aw_id_o, bus.w_last_o},
        {8'd0, 3'd3, 2'b01, 4'd0, 1'b1});
    rst = 1'b0;
    step;

    for (int k = 0; k < 8; k++) run_scn(k, tbl[k]);

    // Misaligned base: straight to ERR with no write issued.
    base = 32'h8000_0002; start = 1'b1;
    step;
    start = 1'b0;
    chk("misalign_status", {busy, done, err}, 3'b001);
    q = 0;
    for (int c = 0; c < 3; c++) begin
      if (bus.aw_valid_o || bus.w_valid_o || bus.s_ready_o) q++;
      step;
    end
    chk("misalign_no_axi", q, 0);

    // Load into RESP, ignore a start while busy, then reset mid-transaction.
    base = 32'h0000_0040; start = 1'b1;
    step;
    start = 1'b0;
    bus.s_valid_i = 1'b1; bus.s_data_i = WA; bus.s_last_i = 1'b0;
    step;
    bus.s_data_i = WB;
    step;
    idle_inputs();
    chk("rr_issue_valids", {bus.aw_valid_o, bus.w_valid_o}, 2'b11);
    bus.aw_ready_i = 1'b1; bus.w_ready_i = 1'b1;
    step;
    idle_inputs();
    chk("rr_in_resp", {bus.b_ready_o, busy}, 2'b11);
    base = 32'h0000_0200; start = 1'b1;
    step;
    start = 1'b0;
    chk("busy_start_ignored", {bus.b_ready_o, bus.aw_addr_o}, {1'b1, 32'h0000_0040});
    rst = 1'b1;
    step;
    chk("rr_status", {busy, done, err, words}, 19'd0);
    chk("rr_handshakes", {bus.s_ready_o, bus.aw_valid_o, bus.w_valid_o, bus.b_ready_o}, 4'd0);
    chk("rr_bus_regs", {bus.aw_addr_o, bus.w_strb_o}, 40'd0);
    chk("rr_wdata", bus.w_data_o, 0);
    rst = 1'b0;
    step;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
